// File: rtl/tx_pkg.sv
// Shared types and default sizes for the DAC transmit burst path.
package tx_pkg;

  localparam int TX_DATA_W    = 12;
  localparam int TX_CNT_W     = 16;
  localparam int TX_DONE_HOLD = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    HIGH    = 3'd2,
    LOW     = 3'd3,
    DONE    = 3'd4,
    RELEASE = 3'd5
  } tx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop level synchronizer with registered rising/falling edge detect.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   q_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= '0;
      q_d     <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
      q_d     <= sync_ff[SYNC_STAGES-1];
    end
  end

  assign q    = sync_ff[SYNC_STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/tx_burst_gen.sv
// Square-wave DAC burst generator: synchronized start, shadowed config,
// HIGH/LOW phase counting and a stretched completion pulse.
module tx_burst_gen
  import tx_pkg::*;
#(
  parameter int DATA_W      = TX_DATA_W,
  parameter int CNT_W       = TX_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int DONE_HOLD   = TX_DONE_HOLD
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tx_en,
  input  logic [CNT_W-1:0]  cfg_half_period,
  input  logic [CNT_W-1:0]  cfg_num_pulses,
  input  logic [DATA_W-1:0] cfg_high_code,
  input  logic [DATA_W-1:0] cfg_low_code,
  input  logic [DATA_W-1:0] cfg_idle_code,
  input  logic              cfg_q_enable,
  output logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_q,
  output logic              tx_active,
  output logic              tx_done,
  output logic              err_cfg
);

  localparam int DONE_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;

  tx_state_t         state, next_state;
  logic              tx_en_s, tx_en_rise, tx_en_fall;
  logic [CNT_W-1:0]  sh_half, sh_num, half_m1;
  logic [DATA_W-1:0] sh_high, sh_low, sh_idle;
  logic              sh_q_en;
  logic [CNT_W-1:0]  phase_cnt, pulse_cnt;
  logic [DONE_W-1:0] done_cnt;
  logic [DATA_W-1:0] idle_code, data_i_n, data_q_n;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (tx_en),
    .q       (tx_en_s),
    .rise    (tx_en_rise),
    .fall    (tx_en_fall)
  );

  assign half_m1 = (sh_half == '0) ? '0 : sh_half - CNT_W'(1);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (tx_en_rise) next_state = ARM;
      ARM: begin
        if (tx_en_fall)          next_state = IDLE;
        else if (sh_num == '0)   next_state = DONE;
        else                     next_state = HIGH;
      end
      HIGH: begin
        if (tx_en_fall)          next_state = IDLE;
        else if (phase_cnt == '0) next_state = LOW;
      end
      LOW: begin
        if (tx_en_fall)          next_state = IDLE;
        else if (phase_cnt == '0)
          next_state = (pulse_cnt == CNT_W'(1)) ? DONE : HIGH;
      end
      DONE:    if (done_cnt == '0) next_state = tx_en_s ? RELEASE : IDLE;
      RELEASE: if (!tx_en_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Shadows are not yet loaded while in IDLE, so idle output follows the live input there.
  always_comb begin
    idle_code = (state == IDLE) ? cfg_idle_code : sh_idle;
    data_i_n  = idle_code;
    data_q_n  = idle_code;
    case (next_state)
      HIGH: begin
        data_i_n = sh_high;
        data_q_n = sh_q_en ? sh_low : sh_idle;
      end
      LOW: begin
        data_i_n = sh_low;
        data_q_n = sh_q_en ? sh_high : sh_idle;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      data_i    <= '0;
      data_q    <= '0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      err_cfg   <= 1'b0;
    end else begin
      state     <= next_state;
      data_i    <= data_i_n;
      data_q    <= data_q_n;
      tx_active <= (next_state == HIGH) || (next_state == LOW);
      tx_done   <= (next_state == DONE);
      err_cfg   <= (state == IDLE) && (next_state == ARM) && (cfg_num_pulses == '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_half <= '0;
      sh_num  <= '0;
      sh_high <= '0;
      sh_low  <= '0;
      sh_idle <= '0;
      sh_q_en <= 1'b0;
    end else if (state == IDLE && tx_en_rise) begin
      sh_half <= cfg_half_period;
      sh_num  <= cfg_num_pulses;
      sh_high <= cfg_high_code;
      sh_low  <= cfg_low_code;
      sh_idle <= cfg_idle_code;
      sh_q_en <= cfg_q_enable;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_cnt <= '0;
      pulse_cnt <= '0;
      done_cnt  <= '0;
    end else begin
      case (state)
        ARM: begin
          phase_cnt <= half_m1;
          pulse_cnt <= sh_num;
        end
        HIGH: phase_cnt <= (phase_cnt == '0) ? half_m1 : phase_cnt - CNT_W'(1);
        LOW: begin
          if (phase_cnt == '0) begin
            phase_cnt <= half_m1;
            pulse_cnt <= pulse_cnt - CNT_W'(1);
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
      done_cnt <= (state == DONE) ? done_cnt - DONE_W'(1) : DONE_W'(DONE_HOLD - 1);
    end
  end

endmodule

// File: tb/tb_tx_burst_gen.sv
// Scoreboard bench for tx_burst_gen: per-cycle expected outputs from a waveform model.
module tb_tx_burst_gen;

  localparam int DATA_W = 12;
  localparam int CNT_W  = 16;
  localparam int HOLD   = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              tx_en;
  logic [CNT_W-1:0]  cfg_half_period, cfg_num_pulses;
  logic [DATA_W-1:0] cfg_high_code, cfg_low_code, cfg_idle_code;
  logic              cfg_q_enable;
  logic [DATA_W-1:0] data_i, data_q;
  logic              tx_active, tx_done, err_cfg;

  typedef struct {
    int unsigned       cyc;
    logic [DATA_W-1:0] di;
    logic [DATA_W-1:0] dq;
    logic              act;
    logic              done;
    logic              err;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          nchecks = 0;
  int          nerr = 0;

  tx_burst_gen #(
    .DATA_W      (DATA_W),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2),
    .DONE_HOLD   (HOLD)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .tx_en           (tx_en),
    .cfg_half_period (cfg_half_period),
    .cfg_num_pulses  (cfg_num_pulses),
    .cfg_high_code   (cfg_high_code),
    .cfg_low_code    (cfg_low_code),
    .cfg_idle_code   (cfg_idle_code),
    .cfg_q_enable    (cfg_q_enable),
    .data_i          (data_i),
    .data_q          (data_q),
    .tx_active       (tx_active),
    .tx_done         (tx_done),
    .err_cfg         (err_cfg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    nchecks++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, want);
    end
  endtask

  // Monitor: compares DUT outputs whenever the scoreboard holds an entry for this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      nchecks++;
      nerr++;
      $display("FAIL sb_stale: entry for cyc %0d never compared (now %0d)", e.cyc, cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("out{di,dq,act,done,err}",
          64'({data_i, data_q, tx_active, tx_done, err_cfg}),
          64'({e.di, e.dq, e.act, e.done, e.err}));
    end
  end

  function automatic void push(input int unsigned c, input logic [DATA_W-1:0] di,
                               input logic [DATA_W-1:0] dq, input logic act,
                               input logic done, input logic err);
    exp_t e;
    e.cyc = c; e.di = di; e.dq = dq; e.act = act; e.done = done; e.err = err;
    sb.push_back(e);
  endfunction

  // Sample i of a burst: alternating half-periods of hm cycles, starting high.
  function automatic void push_sample(input int unsigned c, input int i, input int hm,
                                      input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo,
                                      input logic [DATA_W-1:0] idl, input bit qen);
    bit high;
    high = ((i / hm) % 2) == 0;
    push(c, high ? hi : lo, qen ? (high ? lo : hi) : idl, 1'b1, 1'b0, 1'b0);
  endfunction

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_cfg(input int h, input int n, input logic [DATA_W-1:0] hi,
                         input logic [DATA_W-1:0] lo, input logic [DATA_W-1:0] idl, input bit qen);
    cfg_half_period = CNT_W'(h);
    cfg_num_pulses  = CNT_W'(n);
    cfg_high_code   = hi;
    cfg_low_code    = lo;
    cfg_idle_code   = idl;
    cfg_q_enable    = qen;
  endtask

  // Called at a negedge with the DUT idle; abort_idx >= 0 drops tx_en before burst sample abort_idx.
  task automatic run_burst(input int h, input int n, input logic [DATA_W-1:0] hi,
                           input logic [DATA_W-1:0] lo, input logic [DATA_W-1:0] idl,
                           input bit qen, input int abort_idx, input int hold);
    int unsigned k, j, d0;
    int hm, len;
    set_cfg(h, n, hi, lo, idl, qen);
    tx_en = 1'b1;
    k   = cyc + 1;
    hm  = (h == 0) ? 1 : h;
    len = 2 * hm * n;
    push(k,     idl, idl, 1'b0, 1'b0, 1'b0);
    push(k + 1, idl, idl, 1'b0, 1'b0, 1'b0);
    push(k + 2, idl, idl, 1'b0, 1'b0, n == 0);
    if (abort_idx >= 0 && len >= 2) begin
      j = k + 3 + abort_idx;
      for (int i = 0; i <= abort_idx + 1; i++) push_sample(k + 3 + i, i, hm, hi, lo, idl, qen);
      for (int unsigned c = j + 2; c <= j + 11; c++) push(c, idl, idl, 1'b0, 1'b0, 1'b0);
      wait_until(j - 1);
      tx_en = 1'b0;
      wait_until(j + 11);
    end else begin
      for (int i = 0; i < len; i++) push_sample(k + 3 + i, i, hm, hi, lo, idl, qen);
      d0 = k + 3 + len;
      for (int unsigned c = d0; c < d0 + HOLD; c++) push(c, idl, idl, 1'b0, 1'b1, 1'b0);
      for (int unsigned c = d0 + HOLD; c <= d0 + hold + 9; c++) push(c, idl, idl, 1'b0, 1'b0, 1'b0);
      wait_until(d0 + HOLD + hold);
      tx_en = 1'b0;
      wait_until(d0 + hold + 9);
    end
  endtask

  task automatic reset_mid_low();
    int unsigned k, r;
    set_cfg(5, 4, 12'hABC, 12'h123, 12'h800, 1'b1);
    tx_en = 1'b1;
    k = cyc + 1;
    for (int unsigned c = k; c <= k + 2; c++) push(c, 12'h800, 12'h800, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) push_sample(k + 3 + i, i, 5, 12'hABC, 12'h123, 12'h800, 1'b1);
    wait_until(k + 9);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    tx_en   = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({data_i, data_q, tx_active, tx_done, err_cfg}), 64'd0);
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b1;
    r = cyc;
    for (int unsigned c = r + 1; c <= r + 10; c++) push(c, 12'h800, 12'h800, 1'b0, 1'b0, 1'b0);
    wait_until(r + 10);
  endtask

  initial begin
    int unsigned m;
    int h, n, hm, len, ab;
    reset_n = 1'b0;
    tx_en   = 1'b0;
    set_cfg(5, 4, 12'hFFF, 12'h000, 12'h800, 1'b0);
    #3;
    chk("reset_outputs", 64'({data_i, data_q, tx_active, tx_done, err_cfg}), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m = cyc;
    for (int unsigned c = m + 1; c <= m + 20; c++) push(c, 12'h800, 12'h800, 1'b0, 1'b0, 1'b0);
    wait_until(m + 20);

    run_burst(5, 4, 12'hFFF, 12'h000, 12'h800, 1'b0, -1, 12);
    run_burst(0, 2, 12'hFFF, 12'h000, 12'h800, 1'b1, -1, 2);
    run_burst(3, 0, 12'hFFF, 12'h000, 12'h800, 1'b0, -1, 2);
    run_burst(5, 4, 12'hFFF, 12'h000, 12'h800, 1'b0, 11, 0);
    run_burst(5, 4, 12'hFFF, 12'h000, 12'h800, 1'b0, -1, 3);
    reset_mid_low();

    for (int t = 0; t < 14; t++) begin
      h   = $urandom_range(0, 4);
      n   = $urandom_range(0, 3);
      hm  = (h == 0) ? 1 : h;
      len = 2 * hm * n;
      ab  = ($urandom_range(0, 3) == 0 && len >= 2) ? $urandom_range(0, len - 2) : -1;
      run_burst(h, n, DATA_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
                1'($urandom), ab, $urandom_range(0, 5));
    end

    for (int t = 0; t < 50 && sb.size() > 0; t++) @(negedge clk);
    if (sb.size() > 0) begin
      nchecks++;
      nerr++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/tx_burst_gen.md
Name: tx_burst_gen

Overview:
- Square-wave transmit burst generator in the DAC `phy_clk` domain.
- Sits directly upstream of the DAC SelectIO output stage and drives its 12-bit I/Q sample words.
- Started by the main controller's `tx_en` level. Returns a stretched `tx_done` pulse that the slower ADC-clock controller can sample before it starts receive counting.

Parameters:
- DATA_W, 12, DAC sample width per channel.
- CNT_W, 16, width of the period and pulse counters.
- SYNC_STAGES, 2, flops in the `tx_en` synchronizer (minimum 2).
- DONE_HOLD, 3, cycles that `tx_done` stays high.

Ports:
- clk, input, 1, DAC `phy_clk`; every register is on the rising edge.
- reset_n, input, 1, asynchronous, active-low reset.
- tx_en, input, 1, burst request level from the controller; asynchronous to clk.
- cfg_half_period, input, CNT_W, clk cycles per half pulse; 0 is treated as 1.
- cfg_num_pulses, input, CNT_W, number of full high/low pulse periods.
- cfg_high_code, input, DATA_W, DAC code for the high half.
- cfg_low_code, input, DATA_W, DAC code for the low half.
- cfg_idle_code, input, DATA_W, DAC code driven outside a burst.
- cfg_q_enable, input, 1, 1 = Q channel carries the complementary waveform.
- data_i, output, DATA_W, registered I sample to SelectIO.
- data_q, output, DATA_W, registered Q sample to SelectIO.
- tx_active, output, 1, high while in HIGH or LOW.
- tx_done, output, 1, completion pulse, DONE_HOLD cycles long.
- err_cfg, output, 1, one-cycle pulse when a burst is started with cfg_num_pulses = 0.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE; all counters 0; synchronizer flops 0.
  - data_i = 0, data_q = 0, tx_active = 0, tx_done = 0, err_cfg = 0.
- Synchronizer and start edge:
  - tx_en passes through SYNC_STAGES flops to give tx_en_s.
  - Start = tx_en_s high with the previous tx_en_s low (registered edge detect).
- States: IDLE, ARM, HIGH, LOW, DONE, RELEASE.
- IDLE:
  - data_i = data_q = cfg_idle_code, from the first clock after reset release.
  - On start, go to ARM.
- ARM (1 cycle):
  - Latch every cfg_* input into shadow registers; cfg changes during a burst have no effect.
  - half = max(cfg_half_period, 1).
  - If num_pulses = 0: pulse err_cfg and go to DONE.
  - Otherwise: pulse_cnt = num_pulses, phase_cnt = half - 1, go to HIGH.
- HIGH:
  - data_i = high_code.
  - data_q = low_code if q_enable, else idle_code.
  - phase_cnt decrements each cycle. At 0: reload to half - 1 and go to LOW.
- LOW:
  - data_i = low_code.
  - data_q = high_code if q_enable, else idle_code.
  - phase_cnt decrements each cycle. At 0, decrement pulse_cnt:
    - result 0: go to DONE;
    - otherwise: reload phase_cnt and go to HIGH.
- Burst length: exactly 2 × half × num_pulses cycles with tx_active high, no gaps.
- DONE:
  - Outputs return to idle_code.
  - tx_done is high for exactly DONE_HOLD cycles, then go to RELEASE.
- RELEASE:
  - Hold idle; wait for tx_en_s low, then go to IDLE.
  - This prevents retrigger while the controller still holds tx_en.
- Start latency: with tx_en rising before clk edge k, tx_en_s is high after edge k+SYNC_STAGES-1.
  - ARM is entered at edge k+SYNC_STAGES.
  - The first high_code appears on data_i after edge k+SYNC_STAGES+1 (edge k+3 when SYNC_STAGES = 2).
- Abort: tx_en_s falling while in ARM, HIGH or LOW:
  - go to IDLE on the next edge, with idle_code on the outputs;
  - tx_done is not asserted.
- tx_en low during DONE: the tx_done hold completes in full, then go to IDLE.
- Start edge in any state other than IDLE is ignored.
- Counter wrap: counters never wrap. cfg_num_pulses = 2^CNT_W - 1 with cfg_half_period = 2^CNT_W - 1 must run to completion.
- Outputs are fully registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package `tx_pkg`:
  - state encoding enum (IDLE = 0, ARM, HIGH, LOW, DONE, RELEASE);
  - defaults DATA_W = 12, CNT_W = 16, DONE_HOLD = 3.
- Sub-module `sync_edge`: parameterised SYNC_STAGES synchronizer plus rising/falling edge outputs. It is reused later for other okClk-to-`phy_clk` controls.
- The FSM and counters stay in tx_burst_gen.

Test Plan:
- Reset, then idle_code = 0x800 -> data_i = data_q = 0x800 and tx_done = 0 for 20 cycles.
- Basic burst: half = 5, pulses = 4, high = 0xFFF, low = 0x000, q_en = 0, tx_en raised and held:
  - data_i = 0xFFF×5, 0x000×5, repeated 4 times (40 cycles);
  - first 0xFFF on edge k+3; tx_active high for 40 cycles;
  - tx_done high for exactly 3 cycles; data_q = 0x800 throughout;
  - no second burst until tx_en drops and rises again.
- half = 0, pulses = 2, q_en = 1:
  - data_i sequence is high, low, high, low (1 cycle each);
  - data_q is the complement (low, high, low, high).
- pulses = 0 -> err_cfg pulses once in the ARM cycle; tx_active never rises; tx_done high for 3 cycles.
- Abort: tx_en dropped in cycle 12 of a half = 5, pulses = 4 burst:
  - data_i returns to idle_code within SYNC_STAGES + 1 cycles;
  - tx_done never asserts;
  - a fresh tx_en rise starts a full 40-cycle burst.
- reset_n asserted mid-LOW -> all outputs 0 immediately (asynchronous); after release, idle_code is driven and no tx_done appears.
